addsub_op_sequencer: RTL and testbench
======================================

Name: addsub_op_sequencer

Overview:
Multi-cycle ALU sequencer for the MPU datapath. It owns the shared 8-bit adder/subtractor and accepts one operation at a time through a start/busy/done handshake. It executes ADD, SUB, INC, DEC and CMP in one execute cycle, and MUL (low byte) as 8 shift-and-add iterations through the same adder. It sits between the control unit and the accumulator/flag registers.

Parameters:
MUL_ENABLE, 1, 1 = MUL supported; 0 = opcode 101 treated as reserved (NOP).

Ports:
iClk  input  1  system clock; all state updates on rising edge
iRst  input  1  synchronous, active-high reset
iStart  input  1  request; sampled only in IDLE
iOp  input  3  opcode: 000 ADD, 001 SUB, 010 INC, 011 DEC, 100 CMP, 101 MUL, 110/111 reserved
iA  input  8  operand A, latched on accept
iB  input  8  operand B, latched on accept
oBusy  output  1  high whenever state is not IDLE
oDone  output  1  one-cycle completion pulse
oResult  output  8  registered result
oZero  output  1  registered: result/difference == 0
oSign  output  1  registered: bit 7 of result/difference

Behaviour:
- Reset (iRst=1 at an edge, dominates everything, including mid-operation): state IDLE; oResult=0x00; oZero=0; oSign=0; oDone=0; oBusy=0; iteration counter=0; operand and product registers=0.
- States: IDLE, EXEC, MUL, DONE.
- IDLE: iStart=1 accepts the request. It latches iOp, iA and iB. Next state is MUL for op 101 with MUL_ENABLE=1; otherwise EXEC. iStart=0 keeps IDLE.
- Requests outside IDLE are ignored, including EXEC, MUL and DONE. No queueing.
- EXEC (1 cycle): adder inputs are set per op:
  - ADD: A + B, sub=0
  - SUB: A - B, sub=1
  - INC: A + 0x01, sub=0
  - DEC: A - 0x01, sub=1
  - CMP: A - B, sub=1
- EXEC register update at the end of the cycle:
  - ADD/SUB/INC/DEC: oResult = adder sum; flags from the sum.
  - CMP: flags from the difference; oResult holds its previous value.
  - Reserved op: oResult and flags hold.
  - Next state: DONE.
- MUL: the product register is cleared on accept. A shifted-multiplicand register is loaded with A, and the multiplier register with B. There are 8 iterations, counter 0..7, one per cycle:
  - If multiplier bit[counter]=1: product <= product + multiplicand through the adder (sub=0); else product holds.
  - Multiplicand shifts left 1 (zeros in; bits shifted past bit 7 are discarded).
  - After counter=7: oResult = product; flags from product; next state DONE.
  - The result is (A*B) mod 256. There is no early termination.
- DONE: oDone=1 for exactly this cycle; next state IDLE unconditionally.
- Latency: accept edge at cycle k. oDone is high in cycle k+2 for EXEC ops and k+10 for MUL.
- With iStart held high continuously, a new accept occurs in the IDLE cycle after DONE. Throughput is 1 op per 3 cycles for EXEC ops and 11 cycles for MUL.
- oBusy = (state != IDLE) and is high during DONE. oResult and flags are stable from DONE until the next completion.
- Arithmetic is 8-bit with wrap-around. No carry or overflow output (the adder provides none).

Decomposition:
- Shared package addsub_seq_pkg holds:
  - opcode constants (OP_ADD..OP_MUL)
  - state encodings (ST_IDLE, ST_EXEC, ST_MUL, ST_DONE)
  - MUL_ITERS = 8
- One sub-module: the existing team block m8bitAdderSubtractor, instantiated once. The sequencer drives its iA, iB and iSub through an operand mux and reads oAddSub.
- All control and registers stay in addsub_op_sequencer.

Test Plan:
- ADD iA=0x7F iB=0x01, 1-cycle iStart → oDone at k+2; oResult=0x80, oSign=1, oZero=0; oBusy high k+1..k+2.
- SUB 0x05-0x05, then CMP iA=0x03 iB=0x09 → SUB: oResult=0x00, oZero=1. CMP: oResult stays 0x00, oSign=1 (0xFA), oZero=0.
- MUL 0x0D*0x0B → oDone at k+10, oResult=0x8F, oSign=1. Then MUL 0x10*0x10 → oResult=0x00, oZero=1 (wrap).
- iStart pulsed during MUL iteration 3 with ADD operands → ignored; MUL completes with the correct value; exactly one oDone.
- iRst asserted during MUL iteration 4 → next cycle: IDLE, oBusy=0, oResult=0x00, flags 0, no oDone. A following INC 0xFF → oResult=0x00, oZero=1.
- Reserved op 110 after ADD result 0x42 → oDone at k+2; oResult=0x42, flags unchanged. With MUL_ENABLE=0, op 101 behaves identically.

Source files
------------

// File: rtl/addsub_seq_pkg.sv
// addsub_seq_pkg: opcodes, FSM states and iteration count shared by the ALU sequencer
package addsub_seq_pkg;
  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_INC = 3'd2;
  localparam logic [2:0] OP_DEC = 3'd3;
  localparam logic [2:0] OP_CMP = 3'd4;
  localparam logic [2:0] OP_MUL = 3'd5;
  localparam int MUL_ITERS = 8;
  typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_MUL, ST_DONE} state_t;
endpackage

// File: rtl/m8bitAdderSubtractor.sv
// m8bitAdderSubtractor: 8-bit wrap-around adder/subtractor, two's complement subtract when iSub=1
module m8bitAdderSubtractor (
  input  logic [7:0] iA,
  input  logic [7:0] iB,
  input  logic       iSub,
  output logic [7:0] oAddSub
);
  assign oAddSub = iA + (iB ^ {8{iSub}}) + {7'd0, iSub};
endmodule

// File: rtl/addsub_op_sequencer.sv
// addsub_op_sequencer: start/busy/done ALU sequencer sharing one adder for single-cycle ops and shift-add MUL
module addsub_op_sequencer
  import addsub_seq_pkg::*;
#(
  parameter bit MUL_ENABLE = 1'b1
) (
  input  logic       iClk,
  input  logic       iRst,
  input  logic       iStart,
  input  logic [2:0] iOp,
  input  logic [7:0] iA,
  input  logic [7:0] iB,
  output logic       oBusy,
  output logic       oDone,
  output logic [7:0] oResult,
  output logic       oZero,
  output logic       oSign
);
  state_t     r_state;
  logic [2:0] r_op;
  logic [7:0] r_a, r_b, r_prod, r_result;
  logic [3:0] r_cnt;
  logic       r_done, r_zero, r_sign;
  logic [7:0] w_add_a, w_add_b, w_sum;
  logic       w_sub, w_is_mul;
  always_comb begin
    w_is_mul = r_state == ST_MUL;
    w_add_a  = w_is_mul ? r_prod : r_a;
    w_add_b  = w_is_mul ? r_a : (r_op == OP_INC || r_op == OP_DEC) ? 8'h01 : r_b;
    w_sub    = !w_is_mul && (r_op == OP_SUB || r_op == OP_DEC || r_op == OP_CMP);
  end
  m8bitAdderSubtractor u_addsub (
    .iA      (w_add_a),
    .iB      (w_add_b),
    .iSub    (w_sub),
    .oAddSub (w_sum)
  );
  // MUL spends one extra cycle at r_cnt == MUL_ITERS to publish the product
  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_state  <= ST_IDLE;
      r_op     <= OP_ADD;
      r_a      <= 8'h00;
      r_b      <= 8'h00;
      r_prod   <= 8'h00;
      r_cnt    <= 4'd0;
      r_result <= 8'h00;
      r_zero   <= 1'b0;
      r_sign   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: if (iStart) begin
          r_op    <= iOp;
          r_a     <= iA;
          r_b     <= iB;
          r_prod  <= 8'h00;
          r_cnt   <= 4'd0;
          r_state <= (MUL_ENABLE && iOp == OP_MUL) ? ST_MUL : ST_EXEC;
        end
        ST_EXEC: begin
          if (r_op < OP_CMP) r_result <= w_sum;
          if (r_op <= OP_CMP) begin
            r_zero <= w_sum == 8'h00;
            r_sign <= w_sum[7];
          end
          r_done  <= 1'b1;
          r_state <= ST_DONE;
        end
        ST_MUL: if (r_cnt == 4'(MUL_ITERS)) begin
          r_result <= r_prod;
          r_zero   <= r_prod == 8'h00;
          r_sign   <= r_prod[7];
          r_done   <= 1'b1;
          r_state  <= ST_DONE;
        end else begin
          if (r_b[r_cnt[2:0]]) r_prod <= w_sum;
          r_a   <= {r_a[6:0], 1'b0};
          r_cnt <= r_cnt + 4'd1;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end
  assign oBusy   = r_state != ST_IDLE;
  assign oDone   = r_done;
  assign oResult = r_result;
  assign oZero   = r_zero;
  assign oSign   = r_sign;
endmodule

// File: tb/tb_addsub_op_sequencer.sv
// tb_addsub_op_sequencer: directed and random ops checked against an arithmetic reference model
module tb_addsub_op_sequencer;
  import addsub_seq_pkg::*;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, sel = 1'b0;
  logic [2:0] op = 3'd0;
  logic [7:0] a = 8'h00, b = 8'h00;
  logic busy0, done0, z0, s0, busy1, done1, z1, s1;
  logic [7:0] res0, res1;
  logic busy, done, z, s;
  logic [7:0] res;
  int checks = 0, errors = 0;
  logic [7:0] m_res [2];
  logic m_z [2];
  logic m_s [2];
  always #5 clk = ~clk;
  addsub_op_sequencer dut0 (
    .iClk(clk), .iRst(rst), .iStart(start && !sel), .iOp(op), .iA(a), .iB(b),
    .oBusy(busy0), .oDone(done0), .oResult(res0), .oZero(z0), .oSign(s0)
  );
  addsub_op_sequencer #(.MUL_ENABLE(1'b0)) dut1 (
    .iClk(clk), .iRst(rst), .iStart(start && sel), .iOp(op), .iA(a), .iB(b),
    .oBusy(busy1), .oDone(done1), .oResult(res1), .oZero(z1), .oSign(s1)
  );
  assign busy = sel ? busy1 : busy0;
  assign done = sel ? done1 : done0;
  assign res  = sel ? res1 : res0;
  assign z    = sel ? z1 : z0;
  assign s    = sel ? s1 : s0;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_res[i] = 8'h00;
      m_z[i] = 1'b0;
      m_s[i] = 1'b0;
    end
  endtask
  task automatic model(input int d, input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
    logic [7:0] r;
    bit mul_ok;
    mul_ok = (o == OP_MUL) && (d == 0);
    case (o)
      OP_ADD:  r = 8'(x + y);
      OP_SUB:  r = 8'(x - y);
      OP_INC:  r = 8'(x + 8'd1);
      OP_DEC:  r = 8'(x - 8'd1);
      OP_CMP:  r = 8'(x - y);
      default: r = mul_ok ? 8'(int'(x) * int'(y)) : m_res[d];
    endcase
    if (o <= OP_CMP || mul_ok) begin
      m_z[d] = r == 8'h00;
      m_s[d] = r[7];
    end
    if (o < OP_CMP || mul_ok) m_res[d] = r;
  endtask
  task automatic run_op(input int d, input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                        input int inj, input int rst_at, input string tag);
    int lat, cyc;
    lat = (o == OP_MUL && d == 0) ? 10 : 2;
    sel = d == 1;
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 1;
    check({tag, " busy"}, busy, 1);
    while (!done && cyc < 20) begin
      if (cyc == inj) begin
        start = 1'b1; op = OP_ADD; a = 8'h11; b = 8'h22;
      end
      if (cyc == rst_at) rst = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      cyc++;
      if (rst) begin
        rst = 1'b0;
        model_reset();
        check({tag, " rst busy"}, busy, 0);
        check({tag, " rst done"}, done, 0);
        check({tag, " rst result"}, res, 0);
        check({tag, " rst zero"}, z, 0);
        check({tag, " rst sign"}, s, 0);
        return;
      end
    end
    check({tag, " latency"}, cyc, lat);
    model(d, o, x, y);
    check({tag, " result"}, res, m_res[d]);
    check({tag, " zero"}, z, m_z[d]);
    check({tag, " sign"}, s, m_s[d]);
    check({tag, " busy in done"}, busy, 1);
    @(posedge clk);
    #1;
    check({tag, " done pulse"}, done, 0);
    check({tag, " idle"}, busy, 0);
  endtask
  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset result", res, 0);
    check("reset zero", z, 0);
    check("reset sign", s, 0);
    rst = 1'b0;
    run_op(0, OP_ADD, 8'h7F, 8'h01, -1, -1, "add 7f+1");
    run_op(0, OP_SUB, 8'h05, 8'h05, -1, -1, "sub 5-5");
    run_op(0, OP_CMP, 8'h03, 8'h09, -1, -1, "cmp 3,9");
    run_op(0, OP_MUL, 8'h0D, 8'h0B, -1, -1, "mul d*b");
    run_op(0, OP_MUL, 8'h10, 8'h10, -1, -1, "mul wrap");
    run_op(0, OP_MUL, 8'h07, 8'h06, 4, -1, "mul ignore start");
    run_op(0, OP_MUL, 8'h37, 8'h5B, -1, 5, "mul reset");
    run_op(0, OP_INC, 8'hFF, 8'h00, -1, -1, "inc ff");
    run_op(0, OP_ADD, 8'h40, 8'h02, -1, -1, "add 42");
    run_op(0, 3'd6, 8'h12, 8'h34, -1, -1, "reserved 6");
    run_op(0, 3'd7, 8'hFF, 8'hFF, -1, -1, "reserved 7");
    run_op(1, OP_ADD, 8'h40, 8'h02, -1, -1, "nomul add");
    run_op(1, OP_MUL, 8'h03, 8'h04, -1, -1, "nomul op5");
    run_op(1, OP_DEC, 8'h00, 8'h00, -1, -1, "nomul dec");
    for (int i = 0; i < 40; i++)
      run_op(0, 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), -1, -1, "random");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
